// File: rtl/carrier_acq_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// carrier_acq_sequencer_pkg
// Shared definitions for the carrier acquisition sequencer:
//   - acquisition state encoding (also the acqState status readback code)
//   - acqTrackControl codes driven to the loop filter gain select
//   - bit offsets of the sequencer fields inside the status register
//   - small decode helpers mapping a state to its registered control outputs
// ---------------------------------------------------------------------------
package carrier_acq_sequencer_pkg;

    // Code 3'd7 is deliberately unused; the sequencer recovers from it to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SWEEP  = 3'd2,
        ST_PULLIN = 3'd3,
        ST_TRACK  = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FAIL   = 3'd6
    } acqState_t;

    localparam logic [1:0] ATC_ACQ    = 2'b00;
    localparam logic [1:0] ATC_PULLIN = 2'b01;
    localparam logic [1:0] ATC_TRACK  = 2'b10;

    // Status register layout used by the register block.
    localparam int STATUS_ACQSTATE_LSB = 32'd0;
    localparam int STATUS_ACQSTATE_W   = 32'd3;
    localparam int STATUS_LOCKED_BIT   = 32'd3;
    localparam int STATUS_ACQFAIL_BIT  = 32'd4;
    localparam int STATUS_RELOCK_LSB   = 32'd8;
    localparam int STATUS_RELOCK_W     = 32'd8;

    // Gain-select code for the state the loop is entering.
    function automatic logic [1:0] trackCodeFor(input acqState_t st);
        logic [1:0] code;
        case (st)
            ST_PULLIN: code = ATC_PULLIN;
            ST_TRACK:  code = ATC_TRACK;
            ST_HOLD:   code = ATC_TRACK;
            default:   code = ATC_ACQ;
        endcase
        return code;
    endfunction

    // Loop error is forced to zero whenever the loop is not actively closing.
    function automatic logic zeroErrorFor(input acqState_t st);
        logic z;
        case (st)
            ST_IDLE:  z = 1'b1;
            ST_CLEAR: z = 1'b1;
            ST_FAIL:  z = 1'b1;
            default:  z = 1'b0;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/carrier_acq_timer.sv
// ---------------------------------------------------------------------------
// carrier_acq_timer
// Tick counter used for the pull-in qualification and lock-loss hold windows.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        synchronous clear (has priority over advance)
//   advance      count one tick (already qualified with clkEn by the caller)
//   limit        terminal value to compare against
//   count        current tick count
//   atLimit      count == limit (compare is done before any increment, so the
//                caller never advances past the terminal value)
// ---------------------------------------------------------------------------
module carrier_acq_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [TIMER_W-1:0] limit,
    output logic [TIMER_W-1:0] count,
    output logic               atLimit
);

    // Tick counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= {TIMER_W{1'b0}};
        end else if (clear) begin
            count <= {TIMER_W{1'b0}};
        end else if (advance) begin
            count <= count + {{(TIMER_W-1){1'b0}}, 1'b1};
        end
    end

    assign atLimit = (count == limit);

endmodule

// File: rtl/carrier_acq_sequencer.sv
// ---------------------------------------------------------------------------
// carrier_acq_sequencer
// Steps the carrier loop through clear -> sweep -> pull-in -> track -> hold,
// re-acquiring after a sustained loss of lock and flagging failure after too
// many sweep reversals. All outputs are registered and decoded from the next
// state so they change on the same edge as the state.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   enable            run; low forces IDLE
//   restart           one-cycle pulse, re-acquire from CLEAR
//   clkEn             loop-filter sample enable; all timing is in clkEn ticks
//   carrierLock       lock detector
//   highFreqOffset    frequency offset too high
//   lagAtLimit        lag accumulator at a limit (sweep reversal)
//   pullInTime        ticks of continuous lock needed in PULLIN
//   holdTime          ticks of lock loss tolerated in HOLD
//   maxSweeps         reversals before FAIL, 0 = unlimited
//   clearAccum, sweepEnable, zeroError, acqTrackControl   loop filter controls
//   acqState, locked, acqFail, relockCount                status
// ---------------------------------------------------------------------------
module carrier_acq_sequencer
    import carrier_acq_sequencer_pkg::*;
#(
    parameter int TIMER_W     = 16,
    parameter int SWEEP_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   restart,
    input  logic                   clkEn,
    input  logic                   carrierLock,
    input  logic                   highFreqOffset,
    input  logic                   lagAtLimit,
    input  logic [TIMER_W-1:0]     pullInTime,
    input  logic [TIMER_W-1:0]     holdTime,
    input  logic [SWEEP_CNT_W-1:0] maxSweeps,
    output logic                   clearAccum,
    output logic                   sweepEnable,
    output logic                   zeroError,
    output logic [1:0]             acqTrackControl,
    output logic [2:0]             acqState,
    output logic                   locked,
    output logic                   acqFail,
    output logic [7:0]             relockCount
);

    acqState_t              stateQ;
    acqState_t              nextState;
    logic [SWEEP_CNT_W-1:0] sweepCount;
    logic [SWEEP_CNT_W-1:0] sweepNext;
    logic                   lagPrev;
    logic                   lagRise;
    logic                   sweepInc;
    logic                   relockInc;
    logic                   doRestart;
    logic                   entryClear;
    logic                   timerAdvance;
    logic                   timerAtLimit;
    logic [TIMER_W-1:0]     timerLimit;
    logic [TIMER_W-1:0]     timerCount;

    // Reversals only count as edges seen between successive clkEn samples.
    assign lagRise   = clkEn && lagAtLimit && !lagPrev;
    // Saturating so an unlimited sweep (maxSweeps == 0) never wraps.
    assign sweepNext = (sweepCount == {SWEEP_CNT_W{1'b1}}) ? sweepCount
                     : sweepCount + {{(SWEEP_CNT_W-1){1'b0}}, 1'b1};
    assign timerLimit = (stateQ == ST_HOLD) ? holdTime : pullInTime;

    // Falling back from PULLIN to SWEEP keeps the counters; every other state
    // entry (including a restart into CLEAR from CLEAR) starts them from zero.
    assign entryClear = doRestart ||
                        ((nextState != stateQ) &&
                         !((stateQ == ST_PULLIN) && (nextState == ST_SWEEP)));

    carrier_acq_timer #(.TIMER_W(TIMER_W)) uTimer (
        .clk     (clk),
        .reset   (reset),
        .clear   (entryClear),
        .advance (timerAdvance),
        .limit   (timerLimit),
        .count   (timerCount),
        .atLimit (timerAtLimit)
    );

    // Next-state decode with enable > restart > normal priority.
    always_comb begin
        nextState    = stateQ;
        timerAdvance = 1'b0;
        sweepInc     = 1'b0;
        relockInc    = 1'b0;
        doRestart    = 1'b0;
        if (!enable) begin
            nextState = ST_IDLE;
        end else if (restart) begin
            nextState = ST_CLEAR;
            doRestart = 1'b1;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    nextState = ST_CLEAR;
                end
                ST_CLEAR: begin
                    // Hold the clear until the loop has seen one enabled sample.
                    if (clkEn) begin
                        nextState = ST_SWEEP;
                    end else begin
                        nextState = ST_CLEAR;
                    end
                end
                ST_SWEEP: begin
                    if (!clkEn) begin
                        nextState = ST_SWEEP;
                    end else if (carrierLock && !highFreqOffset) begin
                        nextState = ST_PULLIN;
                    end else if (lagRise) begin
                        sweepInc = 1'b1;
                        if ((maxSweeps != {SWEEP_CNT_W{1'b0}}) && (sweepNext == maxSweeps)) begin
                            nextState = ST_FAIL;
                        end else begin
                            nextState = ST_SWEEP;
                        end
                    end else begin
                        nextState = ST_SWEEP;
                    end
                end
                ST_PULLIN: begin
                    if (!clkEn) begin
                        nextState = ST_PULLIN;
                    end else if (!carrierLock || highFreqOffset) begin
                        nextState = ST_SWEEP;
                    end else if (timerAtLimit) begin
                        nextState = ST_TRACK;
                    end else begin
                        nextState    = ST_PULLIN;
                        timerAdvance = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (clkEn && !carrierLock) begin
                        nextState = ST_HOLD;
                        relockInc = 1'b1;
                    end else begin
                        nextState = ST_TRACK;
                    end
                end
                ST_HOLD: begin
                    if (!clkEn) begin
                        nextState = ST_HOLD;
                    end else if (carrierLock) begin
                        nextState = ST_TRACK;
                    end else if (timerAtLimit) begin
                        nextState = ST_CLEAR;
                    end else begin
                        nextState    = ST_HOLD;
                        timerAdvance = 1'b1;
                    end
                end
                ST_FAIL: begin
                    nextState = ST_FAIL;
                end
                default: begin
                    nextState = ST_IDLE;
                end
            endcase
        end
    end

    // State, registered control/status outputs and sweep bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ          <= ST_IDLE;
            clearAccum      <= 1'b0;
            sweepEnable     <= 1'b0;
            zeroError       <= 1'b1;
            acqTrackControl <= ATC_ACQ;
            acqState        <= 3'd0;
            locked          <= 1'b0;
            acqFail         <= 1'b0;
            relockCount     <= 8'd0;
            sweepCount      <= {SWEEP_CNT_W{1'b0}};
            lagPrev         <= 1'b0;
        end else begin
            stateQ          <= nextState;
            clearAccum      <= (nextState == ST_CLEAR);
            sweepEnable     <= (nextState == ST_SWEEP);
            zeroError       <= zeroErrorFor(nextState);
            acqTrackControl <= trackCodeFor(nextState);
            acqState        <= nextState;
            locked          <= (nextState == ST_TRACK);

            // Sticky: only a restart clears it, IDLE does not.
            if (doRestart) begin
                acqFail <= 1'b0;
            end else if (nextState == ST_FAIL) begin
                acqFail <= 1'b1;
            end

            if (doRestart) begin
                relockCount <= 8'd0;
            end else if (relockInc && (relockCount != 8'hFF)) begin
                relockCount <= relockCount + 8'd1;
            end

            if (entryClear) begin
                sweepCount <= {SWEEP_CNT_W{1'b0}};
            end else if (sweepInc) begin
                sweepCount <= sweepNext;
            end

            if (clkEn) begin
                lagPrev <= lagAtLimit;
            end
        end
    end

endmodule

// File: tb/tb_carrier_acq_sequencer.sv
module tb_carrier_acq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, restart, clkEn, carrierLock, highFreqOffset, lagAtLimit;
    logic [15:0] pullInTime, holdTime;
    logic [7:0]  maxSweeps;
    logic        clearAccum, sweepEnable, zeroError, locked, acqFail;
    logic [1:0]  acqTrackControl;
    logic [2:0]  acqState;
    logic [7:0]  relockCount;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: state by number, counters as plain integers.
    int mState, mTimer, mSweeps, mRelock;
    bit mFail, mLagPrev;

    typedef struct {
        bit en, rs, ce, lk, hf, lg;
        int st;
        bit fail;
        int rel;
    } vec_t;
    vec_t vecs[$];

    carrier_acq_sequencer #(.TIMER_W(16), .SWEEP_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .clkEn(clkEn), .carrierLock(carrierLock), .highFreqOffset(highFreqOffset),
        .lagAtLimit(lagAtLimit), .pullInTime(pullInTime), .holdTime(holdTime),
        .maxSweeps(maxSweeps), .clearAccum(clearAccum), .sweepEnable(sweepEnable),
        .zeroError(zeroError), .acqTrackControl(acqTrackControl), .acqState(acqState),
        .locked(locked), .acqFail(acqFail), .relockCount(relockCount)
    );

    always #5 clk = ~clk;

    // Expected output word for a state number, from the output table.
    function automatic logic [17:0] expVec(input int s, input bit f, input int r);
        logic clr, swp, zro, lkd;
        logic [1:0] atc;
        logic [2:0] sc;
        logic [7:0] rc;
        clr = (s == 1);
        swp = (s == 2);
        zro = (s == 0) || (s == 1) || (s == 6);
        lkd = (s == 4);
        if (s == 3) atc = 2'b01;
        else if (s == 4 || s == 5) atc = 2'b10;
        else atc = 2'b00;
        sc = 3'(s);
        rc = 8'(r);
        return {sc, clr, swp, zro, atc, lkd, f, rc};
    endfunction

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = {acqState, clearAccum, sweepEnable, zeroError, acqTrackControl,
               locked, acqFail, relockCount};
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual %h (state %0d) required %h (state %0d) at %0t",
                     name, act, act[17:15], exp, exp[17:15], $time);
        end
    endtask

    function automatic void modelReset();
        mState = 0; mTimer = 0; mSweeps = 0; mRelock = 0; mFail = 1'b0; mLagPrev = 1'b0;
    endfunction

    // One clock of the acquisition rules.
    function automatic void modelStep();
        int  nxt;
        bit  tick, rise, restarted;
        nxt = mState;
        tick = clkEn;
        rise = tick && lagAtLimit && !mLagPrev;
        restarted = 1'b0;
        if (!enable) begin
            nxt = 0;
        end else if (restart) begin
            nxt = 1; mFail = 1'b0; mRelock = 0; restarted = 1'b1;
        end else begin
            case (mState)
                0: nxt = 1;
                1: if (tick) nxt = 2;
                2: if (tick) begin
                       if (carrierLock && !highFreqOffset) nxt = 3;
                       else if (rise) begin
                           if (mSweeps < 255) mSweeps++;
                           if (maxSweeps != 0 && mSweeps == int'(maxSweeps)) nxt = 6;
                       end
                   end
                3: if (tick) begin
                       if (!carrierLock || highFreqOffset) nxt = 2;
                       else if (mTimer == int'(pullInTime)) nxt = 4;
                       else mTimer++;
                   end
                4: if (tick && !carrierLock) begin
                       nxt = 5;
                       if (mRelock < 255) mRelock++;
                   end
                5: if (tick) begin
                       if (carrierLock) nxt = 4;
                       else if (mTimer == int'(holdTime)) nxt = 1;
                       else mTimer++;
                   end
                6: nxt = 6;
                default: nxt = 0;
            endcase
        end
        if ((nxt != mState || restarted) && !(mState == 3 && nxt == 2)) begin
            mTimer = 0;
            mSweeps = 0;
        end
        if (nxt == 6) mFail = 1'b1;
        if (tick) mLagPrev = lagAtLimit;
        mState = nxt;
    endfunction

    task automatic drive(input bit en, input bit rs, input bit ce,
                         input bit lk, input bit hf, input bit lg);
        enable = en; restart = rs; clkEn = ce;
        carrierLock = lk; highFreqOffset = hf; lagAtLimit = lg;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic addRow(input bit en, input bit rs, input bit ce, input bit lk,
                          input bit hf, input bit lg, input int st, input bit f,
                          input int rel);
        vec_t v;
        v.en = en; v.rs = rs; v.ce = ce; v.lk = lk; v.hf = hf; v.lg = lg;
        v.st = st; v.fail = f; v.rel = rel;
        vecs.push_back(v);
    endtask

    initial begin
        bit lockLevel;
        pullInTime = 16'd3; holdTime = 16'd5; maxSweeps = 8'd2;

        // ---- reset state ----
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("resetState", expVec(0, 0, 0));
        reset = 1'b1;
        modelReset();

        // ---- directed table: acquire, hold/relock, loss, sweep fail, restart ----
        //      en rs ce lk hf lg   st fail rel
        addRow(1, 0, 0, 0, 0, 0,   1, 0, 0);
        addRow(1, 0, 0, 0, 0, 0,   1, 0, 0);
        addRow(1, 0, 0, 0, 0, 0,   1, 0, 0);
        addRow(1, 0, 1, 0, 0, 0,   2, 0, 0);
        addRow(1, 0, 1, 1, 0, 0,   3, 0, 0);
        addRow(1, 0, 0, 1, 0, 0,   3, 0, 0);
        for (int i = 0; i < 3; i++) addRow(1, 0, 1, 1, 0, 0, 3, 0, 0);
        addRow(1, 0, 1, 1, 0, 0,   4, 0, 0);
        addRow(1, 0, 1, 0, 0, 0,   5, 0, 1);
        addRow(1, 0, 1, 0, 0, 0,   5, 0, 1);
        addRow(1, 0, 1, 1, 0, 0,   4, 0, 1);
        addRow(1, 0, 1, 0, 0, 0,   5, 0, 2);
        for (int i = 0; i < 5; i++) addRow(1, 0, 1, 0, 0, 0, 5, 0, 2);
        addRow(1, 0, 1, 0, 0, 0,   1, 0, 2);
        addRow(1, 0, 1, 0, 0, 0,   2, 0, 2);
        addRow(1, 0, 1, 0, 0, 1,   2, 0, 2);
        addRow(1, 0, 1, 0, 0, 0,   2, 0, 2);
        addRow(1, 0, 1, 0, 0, 1,   6, 1, 2);
        addRow(1, 0, 0, 0, 0, 0,   6, 1, 2);
        addRow(0, 0, 0, 0, 0, 0,   0, 1, 2);
        addRow(1, 0, 0, 0, 0, 0,   1, 1, 2);
        addRow(1, 0, 1, 0, 0, 0,   2, 1, 2);
        addRow(1, 0, 1, 1, 0, 0,   3, 1, 2);
        for (int i = 0; i < 3; i++) addRow(1, 0, 1, 1, 0, 0, 3, 1, 2);
        addRow(1, 0, 1, 1, 0, 0,   4, 1, 2);
        addRow(0, 1, 1, 1, 0, 0,   0, 1, 2);
        addRow(1, 1, 0, 0, 0, 0,   1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rs, vecs[i].ce, vecs[i].lk, vecs[i].hf, vecs[i].lg);
            tick();
            check($sformatf("table[%0d]", i), expVec(vecs[i].st, vecs[i].fail, vecs[i].rel));
        end

        // ---- pullInTime = 0 reaches TRACK on the first PULLIN tick ----
        doReset();
        pullInTime = 16'd0;
        drive(1, 0, 1, 1, 0, 0);
        repeat (3) tick();
        check("pullInZeroPullin", expVec(3, 0, 0));
        tick();
        check("pullInZeroTrack", expVec(4, 0, 0));
        drive(1, 0, 0, 0, 1, 0);
        tick();
        check("noTickIgnored", expVec(4, 0, 0));
        drive(1, 0, 1, 0, 0, 0);
        tick();
        check("trackToHold", expVec(5, 0, 1));

        // ---- asynchronous reset mid-PULLIN ----
        doReset();
        pullInTime = 16'd3;
        drive(1, 0, 1, 1, 0, 0);
        repeat (3) tick();
        check("preAsyncPullin", expVec(3, 0, 0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("asyncReset", expVec(0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        modelReset();

        // ---- randomized run against the reference model ----
        lockLevel = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) begin
                pullInTime = 16'($urandom_range(5));
                holdTime   = 16'($urandom_range(5));
                maxSweeps  = 8'($urandom_range(4));
            end
            if ($urandom_range(9) == 0) lockLevel = ~lockLevel;
            drive($urandom_range(99) != 0, $urandom_range(63) == 0, 1'($urandom_range(1)),
                  lockLevel, $urandom_range(19) == 0, $urandom_range(3) == 0);
            tick();
            check("random", expVec(mState, mFail, mRelock));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
